// File: rtl/gt_cache_pkg.sv
// Shared widths, miss-path FSM states and address helpers
// for the victim-cache miss sequencer.
package gt_cache_pkg;

  localparam int ADDR_W      = 32;
  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    RESP,
    WB
  } state_e;

  function automatic logic [ADDR_W-1:0] line_align(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:OFFSET_BITS],
            {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/gt_victim_ctrl_if.sv
// L1 / victim cache / main memory bundle seen by the
// miss sequencer (master) and its environment (slave).
interface gt_victim_ctrl_if;
  import gt_cache_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_evict_valid;
  logic [ADDR_W-1:0] req_evict_addr;
  logic [LINE_W-1:0] req_evict_data;

  logic              resp_valid;
  logic [LINE_W-1:0] resp_data;
  logic              resp_from_vc;

  logic [ADDR_W-1:0] vc_lookup_addr;
  logic              vc_lookup;
  logic              vc_hit;
  logic [LINE_W-1:0] vc_rdata;
  logic              vc_invalidate;
  logic              vc_insert;
  logic [ADDR_W-1:0] vc_insert_addr;
  logic [LINE_W-1:0] vc_insert_data;
  logic              vc_castout_valid;
  logic [ADDR_W-1:0] vc_castout_addr;
  logic [LINE_W-1:0] vc_castout_data;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;

  modport master (
    input  req_valid, req_addr,
    input  req_evict_valid, req_evict_addr,
    input  req_evict_data,
    output req_ready,
    output resp_valid, resp_data, resp_from_vc,
    output vc_lookup_addr, vc_lookup,
    input  vc_hit, vc_rdata,
    output vc_invalidate,
    output vc_insert, vc_insert_addr,
    output vc_insert_data,
    input  vc_castout_valid, vc_castout_addr,
    input  vc_castout_data,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output req_valid, req_addr,
    output req_evict_valid, req_evict_addr,
    output req_evict_data,
    input  req_ready,
    input  resp_valid, resp_data, resp_from_vc,
    input  vc_lookup_addr, vc_lookup,
    output vc_hit, vc_rdata,
    input  vc_invalidate,
    input  vc_insert, vc_insert_addr,
    input  vc_insert_data,
    output vc_castout_valid, vc_castout_addr,
    output vc_castout_data,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/gt_sat_counter.sv
// Statistics counter that sticks at all-ones instead
// of wrapping.
module gt_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             sat;

  assign sat   = &cnt_q;
  assign cnt_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc_i && !sat) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/gt_victim_ctrl.sv
// Miss sequencer: probes the victim cache, falls back to
// memory, inserts the L1 eviction and writes back castouts.
module gt_victim_ctrl
  import gt_cache_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  gt_victim_ctrl_if.master bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int LAT_W = (MEM_LAT > 1)
                       ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD =
    LAT_W'(MEM_LAT - 1);

  state_e            state_q;
  logic              rdy_q;
  logic              lookup_q;
  logic              resp_q;
  logic              insert_q;
  logic              wr_q;
  logic              from_vc_q;
  logic [LAT_W-1:0]  lat_q;
  logic [ADDR_W-1:0] req_line_q;
  logic              ev_valid_q;
  logic [ADDR_W-1:0] ev_line_q;
  logic [LINE_W-1:0] ev_data_q;
  logic [LINE_W-1:0] line_q;
  logic [ADDR_W-1:0] wb_line_q;
  logic [LINE_W-1:0] wb_data_q;

  logic hit_inc;
  logic miss_inc;

  // The probe result is combinational, so the
  // hit/miss reactions happen within the LOOKUP cycle.
  assign hit_inc  = lookup_q & bus.vc_hit;
  assign miss_inc = lookup_q & ~bus.vc_hit;

  assign bus.req_ready      = rdy_q;
  assign bus.resp_valid     = resp_q;
  assign bus.resp_data      = line_q;
  assign bus.resp_from_vc   = resp_q & from_vc_q;
  assign bus.vc_lookup      = lookup_q;
  assign bus.vc_lookup_addr = req_line_q;
  assign bus.vc_invalidate  = hit_inc;
  assign bus.vc_insert      = insert_q;
  assign bus.vc_insert_addr = ev_line_q;
  assign bus.vc_insert_data = ev_data_q;
  assign bus.mem_rd         = miss_inc;
  assign bus.mem_wr         = wr_q;
  assign bus.mem_addr       = wr_q ? wb_line_q
                                   : req_line_q;
  assign bus.mem_wdata      = wb_data_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b1;
      lookup_q   <= 1'b0;
      resp_q     <= 1'b0;
      insert_q   <= 1'b0;
      wr_q       <= 1'b0;
      from_vc_q  <= 1'b0;
      lat_q      <= '0;
      req_line_q <= '0;
      ev_valid_q <= 1'b0;
      ev_line_q  <= '0;
      ev_data_q  <= '0;
      line_q     <= '0;
      wb_line_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      lookup_q <= 1'b0;
      resp_q   <= 1'b0;
      insert_q <= 1'b0;
      wr_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            req_line_q <= line_align(bus.req_addr);
            ev_valid_q <= bus.req_evict_valid;
            ev_line_q  <=
              line_align(bus.req_evict_addr);
            ev_data_q  <= bus.req_evict_data;
            lookup_q   <= 1'b1;
            rdy_q      <= 1'b0;
            state_q    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (bus.vc_hit) begin
            line_q    <= bus.vc_rdata;
            from_vc_q <= 1'b1;
            resp_q    <= 1'b1;
            insert_q  <= ev_valid_q;
            state_q   <= RESP;
          end else begin
            from_vc_q <= 1'b0;
            lat_q     <= LAT_LOAD;
            state_q   <= MEM_RD;
          end
        end
        MEM_RD: begin
          if (lat_q == '0) begin
            line_q   <= bus.mem_rdata;
            resp_q   <= 1'b1;
            insert_q <= ev_valid_q;
            state_q  <= RESP;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        RESP: begin
          // A castout only exists alongside an insert.
          if (insert_q && bus.vc_castout_valid) begin
            wb_line_q <=
              line_align(bus.vc_castout_addr);
            wb_data_q <= bus.vc_castout_data;
            wr_q      <= 1'b1;
            state_q   <= WB;
          end else begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        WB: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  gt_sat_counter #(
    .CNT_W (CNT_W)
  ) u_hit_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc_i (hit_inc),
    .cnt_o (hit_cnt)
  );

  gt_sat_counter #(
    .CNT_W (CNT_W)
  ) u_miss_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc_i (miss_inc),
    .cnt_o (miss_cnt)
  );

endmodule

// File: tb/tb_gt_victim_ctrl.sv
// Directed bench for gt_victim_ctrl: hit, miss, castout
// writeback, reset abandon, back-to-back, saturation.
module tb_gt_victim_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int checks;
  int errors;
  int acc;
  int bad;

  logic [255:0] d_hit;
  logic [255:0] d_mem;
  logic [255:0] d_junk;
  logic [255:0] d_ev;
  logic [255:0] d_co;

  gt_victim_ctrl_if bus ();

  gt_victim_ctrl #(
    .MEM_LAT (4),
    .CNT_W   (16)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic hit_txn(input logic [31:0] a);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    step();
    bus.req_valid = 1'b0;
    bus.vc_hit    = 1'b1;
    bus.vc_rdata  = d_hit;
    step();
    bus.vc_hit    = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    d_hit  = {16'hFFFF, 16'hEEEE, 16'hDDDD, 16'hCCCC,
              16'hBBBB, 16'hAAAA, 16'h9999, 16'h8888,
              16'h7777, 16'h6666, 16'h5555, 16'h4444,
              16'h3333, 16'h2222, 16'h1111, 16'h0000};
    d_mem  = {8{32'h1234_5678}};
    d_junk = {8{32'hDEAD_BEEF}};
    d_ev   = {8{32'hA5A5_0101}};
    d_co   = {8{32'h5A5A_C0C0}};

    rst_n                = 1'b0;
    bus.req_valid        = 1'b0;
    bus.req_addr         = '0;
    bus.req_evict_valid  = 1'b0;
    bus.req_evict_addr   = '0;
    bus.req_evict_data   = '0;
    bus.vc_hit           = 1'b0;
    bus.vc_rdata         = '0;
    bus.vc_castout_valid = 1'b0;
    bus.vc_castout_addr  = '0;
    bus.vc_castout_data  = '0;
    bus.mem_rdata        = d_junk;

    // Reset state
    step();
    #1;
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_resp", bus.resp_valid, 0);
    chk("rst_strobes", {bus.vc_lookup, bus.mem_rd,
        bus.mem_wr, bus.vc_insert}, 0);
    chk("rst_hitcnt", hit_cnt, 0);
    chk("rst_misscnt", miss_cnt, 0);
    rst_n = 1'b1;
    step();

    // Victim hit
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0300_0003;
    step();
    bus.req_valid = 1'b0;
    bus.vc_hit    = 1'b1;
    bus.vc_rdata  = d_hit;
    #1;
    chk("hit_lookup", bus.vc_lookup, 1);
    chk("hit_laddr", bus.vc_lookup_addr, 32'h0300_0000);
    chk("hit_inval", bus.vc_invalidate, 1);
    chk("hit_nomemrd", bus.mem_rd, 0);
    chk("hit_busy", bus.req_ready, 0);
    step();
    bus.vc_hit   = 1'b0;
    bus.vc_rdata = '0;
    #1;
    chk("hit_resp", bus.resp_valid, 1);
    chk("hit_data", bus.resp_data, d_hit);
    chk("hit_fromvc", bus.resp_from_vc, 1);
    chk("hit_inval_off", bus.vc_invalidate, 0);
    chk("hit_noins", bus.vc_insert, 0);
    chk("hit_cnt1", hit_cnt, 1);
    step();
    #1;
    chk("hit_done", {bus.resp_valid, bus.req_ready}, 1);

    // Victim miss, memory latency 4
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0700_0007;
    step();
    bus.req_valid = 1'b0;
    #1;
    chk("miss_memrd", bus.mem_rd, 1);
    chk("miss_maddr", bus.mem_addr, 32'h0700_0000);
    chk("miss_noinval", bus.vc_invalidate, 0);
    step();
    #1;
    chk("miss_rd_pulse", bus.mem_rd, 0);
    chk("miss_cnt1", miss_cnt, 1);
    chk("miss_hitcnt", hit_cnt, 1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.resp_valid !== 1'b0) bad++;
      step();
      #1;
    end
    chk("miss_early_resp", bad, 0);
    chk("miss_wait_resp", bus.resp_valid, 0);
    bus.mem_rdata = d_mem;
    step();
    bus.mem_rdata = d_junk;
    #1;
    chk("miss_resp", bus.resp_valid, 1);
    chk("miss_data", bus.resp_data, d_mem);
    chk("miss_fromvc", bus.resp_from_vc, 0);
    step();
    #1;
    chk("miss_done", {bus.resp_valid, bus.req_ready}, 1);

    // Miss with eviction into a full victim cache
    bus.req_valid       = 1'b1;
    bus.req_addr        = 32'h0900_0009;
    bus.req_evict_valid = 1'b1;
    bus.req_evict_addr  = 32'h0100_0001;
    bus.req_evict_data  = d_ev;
    step();
    bus.req_valid       = 1'b0;
    bus.req_evict_valid = 1'b0;
    bus.req_evict_addr  = '0;
    bus.req_evict_data  = '0;
    for (int i = 0; i < 4; i++) step();
    bus.mem_rdata = d_mem;
    step();
    bus.mem_rdata        = d_junk;
    bus.vc_castout_valid = 1'b1;
    bus.vc_castout_addr  = 32'h0500_0000;
    bus.vc_castout_data  = d_co;
    #1;
    chk("ev_resp", bus.resp_valid, 1);
    chk("ev_insert", bus.vc_insert, 1);
    chk("ev_iaddr", bus.vc_insert_addr, 32'h0100_0000);
    chk("ev_idata", bus.vc_insert_data, d_ev);
    chk("ev_nowr", bus.mem_wr, 0);
    step();
    bus.vc_castout_valid = 1'b0;
    bus.vc_castout_addr  = '0;
    bus.vc_castout_data  = '0;
    #1;
    chk("wb_wr", {bus.mem_wr, bus.mem_rd}, 2'b10);
    chk("wb_addr", bus.mem_addr, 32'h0500_0000);
    chk("wb_data", bus.mem_wdata, d_co);
    chk("wb_busy", {bus.req_ready, bus.vc_insert}, 0);
    chk("wb_misscnt", miss_cnt, 2);
    step();
    #1;
    chk("wb_done", {bus.mem_wr, bus.req_ready}, 2'b01);

    // Reset in the middle of a memory read
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0B00_0000;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", bus.req_ready, 1);
    chk("mrst_resp", bus.resp_valid, 0);
    chk("mrst_wr", bus.mem_wr, 0);
    chk("mrst_cnts", {hit_cnt, miss_cnt}, 0);
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.resp_valid !== 1'b0) bad++;
      if (bus.mem_wr !== 1'b0) bad++;
      if (bus.req_ready !== 1'b1) bad++;
      step();
    end
    chk("mrst_abandon", bad, 0);

    // Back-to-back hits with req_valid held high
    acc = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0D00_0040;
    bus.vc_hit    = 1'b1;
    bus.vc_rdata  = d_hit;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (bus.req_ready === 1'b1) acc++;
      step();
    end
    bus.req_valid = 1'b0;
    bus.vc_hit    = 1'b0;
    #1;
    chk("b2b_accepts", acc, 3);
    chk("b2b_hitcnt", hit_cnt, 3);
    chk("b2b_sum", hit_cnt + miss_cnt, 3);
    chk("b2b_idle", bus.req_ready, 1);

    // Saturation
    @(negedge clk);
    force dut.u_hit_cnt.cnt_q = 16'hFFFE;
    #1;
    release dut.u_hit_cnt.cnt_q;
    step();
    #1;
    chk("sat_preload", hit_cnt, 16'hFFFE);
    hit_txn(32'h0E00_0000);
    #1;
    chk("sat_first", hit_cnt, 16'hFFFF);
    hit_txn(32'h0E00_0020);
    hit_txn(32'h0E00_0040);
    #1;
    chk("sat_hold", hit_cnt, 16'hFFFF);
    chk("sat_misscnt", miss_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/gt_victim_ctrl.md
Name: gt_victim_ctrl

Overview:
- Miss-path sequencer between the L1 cache, the victim cache (GT_victim) and main memory (GT_main_memory).
- On an L1 miss it probes the victim cache first and falls back to a fixed-latency main-memory read.
- It inserts the L1 eviction into the victim cache and writes any victim castout back to memory.
- One outstanding miss at a time; also keeps saturating hit/miss statistics.

Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 256, cache line width in bits (32-byte line)
- MEM_LAT, 4, main-memory read latency in cycles from mem_rd to mem_rdata valid (>=1)
- CNT_W, 16, statistics counter width

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- req_valid  in  1  L1 miss request
- req_ready  out  1  high only in IDLE
- req_addr  in  ADDR_W  miss address
- req_evict_valid  in  1  L1 has a dirty/valid line to evict with this miss
- req_evict_addr  in  ADDR_W  evicted line address
- req_evict_data  in  LINE_W  evicted line data
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  LINE_W  returned line
- resp_from_vc  out  1  response sourced from the victim cache
- vc_lookup_addr  out  ADDR_W  victim probe address (line-aligned)
- vc_lookup  out  1  probe strobe
- vc_hit  in  1  combinational hit, same cycle as vc_lookup
- vc_rdata  in  LINE_W  hit line, same cycle
- vc_invalidate  out  1  remove the hit entry (exclusive victim cache)
- vc_insert  out  1  insert strobe
- vc_insert_addr  out  ADDR_W  insert address
- vc_insert_data  out  LINE_W  insert data
- vc_castout_valid  in  1  victim cache full; displaced line presented in the same cycle as vc_insert
- vc_castout_addr  in  ADDR_W  displaced line address
- vc_castout_data  in  LINE_W  displaced line data
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address, line-aligned
- mem_wdata  out  LINE_W  write data
- mem_rdata  in  LINE_W  read data
- hit_cnt  out  CNT_W  victim hits
- miss_cnt  out  CNT_W  victim misses

Behaviour:
- Reset (async, RST_N low): state IDLE; all outputs 0 except req_ready=1; counters 0; latched request discarded, no pending write survives. Reset mid-operation is legal and abandons the transaction.
- All outgoing addresses are line-aligned: {addr[ADDR_W-1:5],5'b0}.
- IDLE: on req_valid, latch req_addr and the evict fields, then go to LOOKUP. req_valid while not IDLE is ignored.
- LOOKUP (1 cycle): vc_lookup=1.
  - vc_hit=1: latch vc_rdata, pulse vc_invalidate, hit_cnt+1, go to RESP with resp_from_vc=1.
  - vc_hit=0: miss_cnt+1, pulse mem_rd with mem_addr=req line, go to MEM_RD.
- MEM_RD: down-counter loaded with MEM_LAT-1. When the count reaches 0, latch mem_rdata, go to RESP with resp_from_vc=0.
- RESP (1 cycle): resp_valid=1, resp_data=latched line. If req_evict_valid, pulse vc_insert with the evict address/data.
  - vc_castout_valid in this cycle: latch the castout, go to WB.
  - Otherwise go to IDLE.
- WB (1 cycle): mem_wr=1, mem_addr=castout address, mem_wdata=castout data, then go to IDLE.
- Latency from the accept edge T: hit response at T+2; miss response at T+2+MEM_LAT; WB adds 1 cycle before req_ready returns.
- req_evict_addr equal to req_addr line: the hit entry is invalidated in LOOKUP and the eviction re-inserted in RESP; no special case.
- Counters saturate at all-ones and do not wrap.
- Strobes are single-cycle. mem_rd and mem_wr are never asserted in the same cycle.

Decomposition:
- Shared package gt_cache_pkg: LINE_W, ADDR_W, OFFSET_BITS=5, the state enum (IDLE, LOOKUP, MEM_RD, RESP, WB) and a line_align function.
- Sub-module gt_sat_counter (saturating counter, CNT_W), instantiated twice for hit_cnt and miss_cnt.

Test Plan:
- Reset mid-MEM_RD (RST_N low for 1 cycle) -> req_ready=1, no resp_valid, no mem_wr, counters 0.
- Victim hit: req_addr=0x03000003, vc_hit=1, vc_rdata=0xFFFF_EEEE…0000 -> vc_lookup_addr=0x03000000, resp_valid at T+2 with that data, resp_from_vc=1, vc_invalidate pulsed, hit_cnt=1.
- Victim miss, MEM_LAT=4: req_addr=0x07000007 -> mem_rd with mem_addr=0x07000000, resp_valid at T+6 with mem_rdata, resp_from_vc=0, miss_cnt=1.
- Miss with eviction into a full victim cache: evict 0x01000001 with vc_castout_valid=1, castout addr 0x05000000 -> vc_insert_addr=0x01000000 in RESP; next cycle mem_wr=1, mem_addr=0x05000000, castout data on mem_wdata.
- Back-to-back: req_valid held high across a transaction -> second request accepted only after IDLE; hit_cnt+miss_cnt = number of accepted requests.
- Saturation: preload hit_cnt to 0xFFFE, then 3 hits -> hit_cnt=0xFFFF.
